// File: rtl/dispatch_pkg.sv
// Shared definitions for the instruction dispatch stage: class codes, start-bit
// layout, trap causes, FSM states and the instruction-class decoder.
package dispatch_pkg;

  localparam int unsigned IR_W      = 16;
  localparam int unsigned NUM_UNITS = 5;

  localparam logic [2:0] CLS_ALU   = 3'b000;
  localparam logic [2:0] CLS_ALUI  = 3'b001;
  localparam logic [2:0] CLS_LOAD  = 3'b010;
  localparam logic [2:0] CLS_STORE = 3'b011;
  localparam logic [2:0] CLS_MOV   = 3'b100;
  localparam logic [2:0] CLS_MOVI  = 3'b101;

  localparam int unsigned ST_ALU  = 0;
  localparam int unsigned ST_ALUI = 1;
  localparam int unsigned ST_MLS  = 2;
  localparam int unsigned ST_MOV  = 3;
  localparam int unsigned ST_MOVI = 4;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_FOREIGN = 2'b10,
    CAUSE_TIMEOUT = 2'b11
  } trap_cause_e;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    WAIT,
    RETIRE,
    TRAP
  } state_e;

  typedef struct packed {
    logic                 legal;
    logic [NUM_UNITS-1:0] start;
    logic                 store;
  } decode_t;

  // Illegal words decode to an all-zero start vector so they can never issue.
  function automatic decode_t decode(input logic [IR_W-1:0] word);
    decode_t d;
    d       = '0;
    d.legal = 1'b1;
    case (word[11:9])
      CLS_ALU:   d.start[ST_ALU]  = 1'b1;
      CLS_ALUI:  d.start[ST_ALUI] = 1'b1;
      CLS_LOAD:  d.start[ST_MLS]  = 1'b1;
      CLS_STORE: begin
        d.start[ST_MLS] = 1'b1;
        d.store         = 1'b1;
      end
      CLS_MOV:   d.start[ST_MOV]  = 1'b1;
      CLS_MOVI:  d.start[ST_MOVI] = 1'b1;
      default:   d.legal          = 1'b0;
    endcase
    if (word[15] || !d.legal) begin
      d = '0;
    end
    return d;
  endfunction

endpackage

// File: rtl/dispatch_watchdog.sv
// 8-bit saturating cycle counter that flags a hung execution once it reaches
// TIMEOUT_CYCLES.
module dispatch_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES);

  logic [7:0] count;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && count != 8'hFF) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count >= LIMIT);

endmodule

// File: rtl/dispatch_unit.sv
// Decode-and-dispatch stage: accepts an instruction word, pulses one execution
// FSM start, waits for its done, then retires or traps.
module dispatch_unit
  import dispatch_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ir_valid,
  input  logic [IR_W-1:0]      ir_word,
  output logic                 ir_ready,
  output logic [NUM_UNITS-1:0] start,
  output logic                 ls_store,
  input  logic [NUM_UNITS-1:0] exec_done,
  output logic                 instr_done,
  output logic                 busy,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [IR_W-1:0]      trap_ir,
  input  logic                 trap_clr,
  output logic [CNT_W-1:0]     retired
);

  state_e               state, state_next;
  decode_t              dec_in;
  logic [NUM_UNITS-1:0] start_sel;
  logic                 store_sel;
  trap_cause_e          cause_q;
  logic                 expired;
  logic                 done_ok;
  logic                 done_foreign;
  logic                 wd_run;

  assign dec_in       = decode(ir_word);
  assign done_ok      = (exec_done == start_sel);
  assign done_foreign = |(exec_done & ~start_sel);

  // Counting through DISPATCH makes the count read 1 in the first WAIT cycle.
  assign wd_run = (state == DISPATCH) || (state == WAIT);

  dispatch_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wd_run),
    .en     (wd_run),
    .expired(expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: next-state is defaulted to the current state before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (ir_valid) state_next = dec_in.legal ? DISPATCH : TRAP;
      DISPATCH: state_next = WAIT;
      WAIT: begin
        if (done_foreign)  state_next = TRAP;
        else if (done_ok)  state_next = RETIRE;
        else if (expired)  state_next = TRAP;
      end
      RETIRE:   state_next = IDLE;
      TRAP:     if (trap_clr) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sel <= '0;
      store_sel <= 1'b0;
      trap_ir   <= '0;
      cause_q   <= CAUSE_NONE;
      retired   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ir_valid) begin
            trap_ir   <= ir_word;
            start_sel <= dec_in.start;
            store_sel <= dec_in.store;
            if (!dec_in.legal) cause_q <= CAUSE_ILLEGAL;
          end
        end
        WAIT: begin
          if (done_foreign)  cause_q <= CAUSE_FOREIGN;
          else if (done_ok)  retired <= retired + CNT_W'(1);
          else if (expired)  cause_q <= CAUSE_TIMEOUT;
        end
        TRAP: begin
          if (trap_clr) cause_q <= CAUSE_NONE;
        end
        default: ;
      endcase
    end
  end

  assign ir_ready   = (state == IDLE);
  assign busy       = (state != IDLE);
  assign trap       = (state == TRAP);
  assign instr_done = (state == RETIRE);
  assign start      = (state == DISPATCH) ? start_sel : '0;
  assign ls_store   = (state == DISPATCH) && store_sel;
  assign trap_cause = cause_q;

endmodule

// File: doc/dispatch_unit.md
# dispatch_unit

Instruction decode-and-dispatch stage between the instruction register and the per-class execution FSMs (ALU, ALUI, load/store, MOV, MOVI). It accepts each fetched instruction word from the fetch FSM and decodes its class field. It issues exactly one single-cycle start pulse to the matching execution FSM, then waits for that FSM's done. It returns a single retire pulse to the fetch FSM and traps on illegal encodings, foreign done strobes and hung executions.

## Interface
- TIMEOUT_CYCLES, 64: maximum WAIT cycles before a hang trap; legal range 2..255.
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ir_valid  in  1  fetch FSM presents a new word in ir_word.
- ir_word  in  16  instruction word. [15] reserved (must be 0), [14:12] ALU op, [11:9] class.
- ir_ready  out  1  dispatcher can accept a word; high only in IDLE.
- start  out  5  one-hot start, bits {MOVI, MOV, MLS, ALUI, ALU} = [4:0].
- ls_store  out  1  valid with start[2]: 1 = store, 0 = load.
- exec_done  in  5  done strobes from the execution FSMs, same bit order as start.
- instr_done  out  1  one-cycle retire pulse to the fetch FSM.
- busy  out  1  high in every state except IDLE.
- trap  out  1  high while in TRAP.
- trap_cause  out  2  00 none, 01 illegal encoding, 10 foreign done, 11 timeout.
- trap_ir  out  16  instruction word latched at acceptance.
- trap_clr  in  1  leave TRAP; ignored in any other state.
- retired  out  CNT_W  count of retired instructions; wraps modulo 2^CNT_W.

## Operation
- Class encoding, ir_word[11:9]:
  - 000 ALU, 001 ALUI, 010 LOAD, 011 STORE, 100 MOV, 101 MOVI.
  - 110 and 111 are illegal. ir_word[15]=1 is also illegal.
- States and transitions:
  - IDLE: ir_ready=1. When ir_valid is sampled high, latch ir_word into trap_ir. Illegal word -> TRAP with cause 01; otherwise -> DISPATCH.
  - DISPATCH: drive the one-hot start bit for the latched class (LOAD and STORE both map to bit 2, with ls_store set per class). exec_done is ignored in this state. Clear the watchdog and go to WAIT.
  - WAIT: sample exec_done each cycle.
    - Expected bit set, all others clear -> RETIRE.
    - Any other bit set (with or without the expected bit) -> TRAP with cause 10.
    - No bits set and watchdog reaches TIMEOUT_CYCLES -> TRAP with cause 11.
    - If done arrives in the same cycle the watchdog expires, done wins.
  - RETIRE: instr_done=1 and retired increments by 1 (wrapping), then -> IDLE.
  - TRAP: holds until trap_clr is sampled high, then -> IDLE with trap_cause cleared to 00. trap_ir holds its value until the next acceptance.
- instr_done never pulses for a trapped instruction, and retired does not increment for it.
- Reset values: state IDLE, ir_ready=1, start=0, ls_store=0, instr_done=0, busy=0, trap=0, trap_cause=00, trap_ir=0, retired=0, watchdog=0.
- Reset asserted mid-operation aborts to IDLE immediately, with no start or instr_done pulse emitted.
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.

## Timing
- Acceptance at edge k: start is high for exactly cycle k+1.
- Earliest done is sampled at edge k+2, giving instr_done in cycle k+3. Minimum issue-to-retire latency is therefore 3 cycles.
- Back-to-back throughput is one instruction per 4 cycles minimum: IDLE, DISPATCH, WAIT, RETIRE.
- Watchdog counts WAIT cycles, starting at 1 in the first WAIT cycle. The trap is taken on the edge ending WAIT cycle TIMEOUT_CYCLES.
- ir_valid is ignored while ir_ready=0. The fetch FSM must hold the word until it is accepted.

## Structure
- Shared package dispatch_pkg:
  - class codes: CLS_ALU, CLS_ALUI, CLS_LOAD, CLS_STORE, CLS_MOV, CLS_MOVI.
  - start-bit index constants.
  - trap-cause codes.
  - state enum: IDLE, DISPATCH, WAIT, RETIRE, TRAP.
- One sub-module, dispatch_watchdog:
  - 8-bit saturating counter with clear and enable inputs.
  - expired output, compared against TIMEOUT_CYCLES.

## Test plan
- ALU word 0x2000, exec_done[0] pulsed 2 cycles after start -> start=00001 for 1 cycle, then instr_done pulse, retired=1, trap=0.
- STORE word 0x0600 -> start=00100 with ls_store=1. LOAD word 0x0400 -> start=00100 with ls_store=0. Both retire, retired=2.
- Illegal word 0x0C00, then 0x8000 -> no start pulse, trap=1, cause=01, trap_ir matches the word. After trap_clr, ir_ready=1 and cause=00.
- MOV dispatched, exec_done=00001 returned -> trap with cause=10, no instr_done.
- MOVI dispatched with TIMEOUT_CYCLES=4 and no done -> trap with cause=11 exactly 4 WAIT cycles after start. A second run with done in WAIT cycle 4 -> retires, no trap.
- CNT_W=2 with 5 retires -> retired = 1 (wrap). rst asserted during WAIT -> outputs return to reset values asynchronously.
